// File: rtl/iter_alu.sv
// Iterative ALU: single-step arithmetic/logic ops plus bit-serial shifts and rotates
// sequenced by an IDLE/SHIFT/DONE controller with a valid/ready handshake on both sides.
module iter_alu #(
  parameter int W  = 8,
  parameter int SW = $clog2(W)
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         In_valid,
  output logic         In_ready,
  input  logic [2:0]   OP,
  input  logic [W-1:0] InputA,
  input  logic [W-1:0] InputB,
  input  logic         SC_in,
  output logic         Out_valid,
  input  logic         Out_ready,
  output logic [W-1:0] Out,
  output logic         Carry,
  output logic         Zero,
  output logic         Parity,
  output logic         Odd,
  output logic         Busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_LSL, OP_LSR, OP_XOR, OP_SNE, OP_SEQ, OP_MSK, OP_ROR
  } op_t;

  localparam logic [W-1:0] W_VAL = W'(W);

  state_t        state;
  op_t           op_q;
  logic          fill_q;
  logic [W-1:0]  res;
  logic          res_c;
  logic [SW-1:0] cnt;

  op_t           op_in;
  logic [W:0]    sum;
  logic          amt_big;
  logic          amt_zero;
  logic [W-1:0]  rot_k;
  logic [W-1:0]  one_res;
  logic          one_c;
  logic          iter;
  logic [SW-1:0] k_load;

  assign op_in    = op_t'(OP);
  assign sum      = {1'b0, InputA} + {1'b0, InputB} + {{W{1'b0}}, SC_in};
  assign amt_big  = (InputB >= W_VAL);
  assign amt_zero = (InputB == '0);
  assign rot_k    = InputB % W_VAL;

  // Result of the accepting edge: either the final answer, or the work-register seed
  // (InputA) when the operation continues bit by bit in SHIFT.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    one_res = InputA;
    one_c   = 1'b0;
    iter    = 1'b0;
    k_load  = InputB[SW-1:0];
    case (op_in)
      OP_ADD: {one_c, one_res} = sum;
      OP_XOR: one_res = InputA ^ InputB;
      OP_SNE: one_res = {{(W-1){1'b0}}, (InputA != InputB)};
      OP_SEQ: one_res = {{(W-1){1'b0}}, (InputA == InputB)};
      OP_MSK: if (!amt_big) one_res = InputA ^ (W'(1) << InputB);
      OP_LSL, OP_LSR: begin
        if (amt_big) begin
          one_res = {W{SC_in}};
          one_c   = SC_in;
        end else if (!amt_zero) begin
          iter = 1'b1;
        end
      end
      OP_ROR: begin
        if (rot_k != '0) begin
          iter   = 1'b1;
          k_load = rot_k[SW-1:0];
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      op_q   <= OP_ADD;
      fill_q <= 1'b0;
      res    <= '0;
      res_c  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (In_valid) begin
            op_q   <= op_in;
            fill_q <= SC_in;
            res    <= one_res;
            res_c  <= one_c;
            if (iter) begin
              cnt   <= k_load;
              state <= SHIFT;
            end else begin
              state <= DONE;
            end
          end
        end
        SHIFT: begin
          case (op_q)
            OP_LSL:  {res_c, res} <= {res, fill_q};
            OP_LSR:  {res, res_c} <= {fill_q, res};
            default: begin
              res   <= {res[0], res[W-1:1]};
              res_c <= res[0];
            end
          endcase
          cnt <= cnt - 1'b1;
          if (cnt == SW'(1)) state <= DONE;
        end
        DONE: begin
          if (Out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign In_ready  = (state == IDLE);
  assign Out_valid = (state == DONE);
  assign Busy      = (state != IDLE);
  assign Out       = res;
  assign Carry     = res_c;
  assign Zero      = ~|res;
  assign Parity    = ^res;
  assign Odd       = res[0];

endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu (W = 8): stimulus pushes hand-computed results,
// a negedge monitor compares every cycle the DUT presents a result.
module tb_iter_alu;

  localparam logic [2:0] ADD = 3'd0, LSL = 3'd1, LSR = 3'd2, XOR = 3'd3,
                         SNE = 3'd4, SEQ = 3'd5, MSK = 3'd6, ROR = 3'd7;

  logic       Clk, Reset_n, In_valid, In_ready, SC_in, Out_valid, Out_ready;
  logic [2:0] OP;
  logic [7:0] InputA, InputB, Out;
  logic       Carry, Zero, Parity, Odd, Busy;

  iter_alu #(.W(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .In_valid(In_valid), .In_ready(In_ready),
    .OP(OP), .InputA(InputA), .InputB(InputB), .SC_in(SC_in),
    .Out_valid(Out_valid), .Out_ready(Out_ready), .Out(Out), .Carry(Carry),
    .Zero(Zero), .Parity(Parity), .Odd(Odd), .Busy(Busy)
  );

  typedef struct {
    string      name;
    logic [7:0] out;
    logic       c, z, p, o;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   seen = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the head entry on every cycle a result is presented, pops on handshake.
  always @(negedge Clk) begin
    if (Reset_n && Out_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_result: got Out=%0h with nothing expected (t=%0t)", Out, $time);
      end else begin
        if (!seen) check({sb[0].name, "_latency"}, cyc - sb[0].acc, sb[0].lat);
        check({sb[0].name, "_out"},    Out,    sb[0].out);
        check({sb[0].name, "_carry"},  Carry,  sb[0].c);
        check({sb[0].name, "_zero"},   Zero,   sb[0].z);
        check({sb[0].name, "_parity"}, Parity, sb[0].p);
        check({sb[0].name, "_odd"},    Odd,    sb[0].o);
        seen = 1;
        if (Out_ready) begin
          void'(sb.pop_front());
          seen = 0;
        end
      end
    end
  end

  task automatic issue(input string name, input logic [2:0] op, input logic [7:0] a, b,
                       input logic sc, input logic [7:0] eo, input logic ec, ez, ep, eodd,
                       input int lat, input bit push);
    int n = 0;
    exp_t e;
    OP = op; InputA = a; InputB = b; SC_in = sc; In_valid = 1'b1;
    while (!In_ready && n < 200) begin
      @(posedge Clk); #1;
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_accept_timeout: got In_ready=0 for 200 cycles, expected 1", name);
    end
    @(posedge Clk); #1;
    e.name = name; e.out = eo; e.c = ec; e.z = ez; e.p = ep; e.o = eodd;
    e.lat = lat; e.acc = cyc - 1;
    if (push) sb.push_back(e);
    // Scramble inputs after acceptance: they must no longer matter.
    In_valid = 1'b0; OP = XOR; InputA = 8'hC3; InputB = 8'h11; SC_in = ~sc;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge Clk);
      n++;
    end
    #1;
    if (n >= 300) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_done_timeout: got %0d entries pending, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_n = 1'b0; In_valid = 1'b0; Out_ready = 1'b1;
    OP = ADD; InputA = '0; InputB = '0; SC_in = 1'b0;
    #3;
    check("rst_in_ready", In_ready, 1);
    check("rst_out_valid", Out_valid, 0);
    check("rst_busy", Busy, 0);
    check("rst_out", Out, 0);
    check("rst_carry", Carry, 0);
    check("rst_zero", Zero, 1);
    check("rst_parity", Parity, 0);
    check("rst_odd", Odd, 0);
    @(posedge Clk); #1 Reset_n = 1'b1;

    issue("add_f0_20", ADD, 8'hF0, 8'h20, 1'b1, 8'h11, 1, 0, 0, 1, 1, 1); wait_done("add_f0_20");

    issue("lsl_81_3", LSL, 8'h81, 8'd3, 1'b1, 8'h0F, 0, 0, 0, 1, 4, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("lsl_in_ready_low", In_ready, 0);
    end
    wait_done("lsl_81_3");

    issue("ror_01_9",  ROR, 8'h01, 8'd9, 1'b0, 8'h80, 1, 0, 1, 0, 2, 1); wait_done("ror_01_9");
    issue("lsr_ff_8",  LSR, 8'hFF, 8'd8, 1'b0, 8'h00, 0, 1, 0, 0, 1, 1); wait_done("lsr_ff_8");
    issue("lsr_96_2",  LSR, 8'h96, 8'd2, 1'b1, 8'hE5, 1, 0, 1, 1, 3, 1); wait_done("lsr_96_2");
    issue("lsl_3c_0",  LSL, 8'h3C, 8'd0, 1'b1, 8'h3C, 0, 0, 0, 0, 1, 1); wait_done("lsl_3c_0");
    issue("lsl_00_9",  LSL, 8'h00, 8'd9, 1'b1, 8'hFF, 1, 0, 0, 1, 1, 1); wait_done("lsl_00_9");
    issue("ror_81_8",  ROR, 8'h81, 8'd8, 1'b0, 8'h81, 0, 0, 0, 1, 1, 1); wait_done("ror_81_8");
    issue("xor_a5_3c", XOR, 8'hA5, 8'h3C, 1'b1, 8'h99, 0, 0, 0, 1, 1, 1); wait_done("xor_a5_3c");
    issue("sne_5a_5b", SNE, 8'h5A, 8'h5B, 1'b0, 8'h01, 0, 0, 1, 1, 1, 1); wait_done("sne_5a_5b");
    issue("msk_55_8",  MSK, 8'h55, 8'd8, 1'b0, 8'h55, 0, 0, 0, 1, 1, 1); wait_done("msk_55_8");
    issue("add_ff_00", ADD, 8'hFF, 8'h00, 1'b0, 8'hFF, 0, 0, 0, 1, 1, 1); wait_done("add_ff_00");
    issue("add_7f_80", ADD, 8'h7F, 8'h80, 1'b1, 8'h00, 1, 1, 0, 0, 1, 1); wait_done("add_7f_80");
    repeat (3) @(negedge Clk);
    check("carry_retained_idle", Carry, 1);
    check("idle_in_ready", In_ready, 1);

    // Consumer stalls: result must hold while new requests are ignored.
    Out_ready = 1'b0;
    issue("seq_5a_5a", SEQ, 8'h5A, 8'h5A, 1'b0, 8'h01, 0, 0, 1, 1, 1, 1);
    for (int i = 0; i < 5; i++) begin
      In_valid = 1'b1; OP = ADD; InputA = 8'h12 + 8'(i); InputB = 8'h34;
      @(posedge Clk); #1;
    end
    In_valid = 1'b0; Out_ready = 1'b1;
    wait_done("seq_5a_5a");
    check("seq_exit_in_ready", In_ready, 1);
    check("seq_exit_out_valid", Out_valid, 0);

    // Reset in the middle of a shift abandons the operation.
    issue("lsr_80_6", LSR, 8'h80, 8'd6, 1'b0, 8'h00, 0, 0, 0, 0, 7, 0);
    @(posedge Clk); #2;
    Reset_n = 1'b0;
    #1;
    check("midrst_in_ready", In_ready, 1);
    check("midrst_busy", Busy, 0);
    check("midrst_out", Out, 0);
    check("midrst_zero", Zero, 1);
    @(posedge Clk); #1 Reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      check("midrst_no_out_valid", Out_valid, 0);
    end
    issue("msk_00_6", MSK, 8'h00, 8'd6, 1'b0, 8'h40, 0, 0, 1, 0, 1, 1); wait_done("msk_00_6");

    repeat (2) @(posedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
